// File: rtl/alu_in_rr_issuer.sv
`timescale 1ns/1ps
// alu_in_rr_issuer: per-channel request FIFOs feeding one registered
// valid/ready ALU input bus through a round-robin arbiter.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   flush             synchronous clear of FIFOs and output stage
//   ch_valid/ch_ready per-channel push handshake (ready = FIFO not full)
//   ch_op/ch_a/ch_b   packed per-channel request payloads
//   alu_valid/ready   ALU bus handshake
//   alu_op/a/b/ch     registered issued request and its source channel
//   ch_level          packed per-channel FIFO occupancy
//   issue_count       wrapping count of completed ALU handshakes
module alu_in_rr_issuer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CH_W      = $clog2(NUM_CH),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_CH-1:0]              ch_valid,
  output logic [NUM_CH-1:0]              ch_ready,
  input  logic [NUM_CH*OP_WIDTH-1:0]     ch_op,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_a,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_b,
  output logic                           alu_valid,
  input  logic                           alu_ready,
  output logic [OP_WIDTH-1:0]            alu_op,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  output logic [CH_W-1:0]                alu_ch,
  output logic [NUM_CH*LVL_W-1:0]        ch_level,
  output logic [15:0]                    issue_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = OP_WIDTH + 2 * DATA_WIDTH;

  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [ENT_W-1:0]  w_ch_head [NUM_CH];
  logic [ENT_W-1:0]  w_head;

  logic [CH_W-1:0]   r_last;
  logic [CH_W-1:0]   w_gnt;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_loadable;
  logic              w_load;

  logic              r_valid;
  logic [OP_WIDTH-1:0]   r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [CH_W-1:0]       r_ch;
  logic [15:0]           r_issue_count;

  // Output stage accepts a new word when empty or being consumed.
  assign w_loadable = !r_valid || alu_ready;
  assign w_load     = w_loadable && w_any && !flush;

  // Per-channel FIFO
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic [ENT_W-1:0] w_wdata;

    assign w_wdata = {ch_op[g*OP_WIDTH +: OP_WIDTH],
                      ch_a[g*DATA_WIDTH +: DATA_WIDTH],
                      ch_b[g*DATA_WIDTH +: DATA_WIDTH]};

    // Ready depends only on the registered level, never on ch_valid.
    assign ch_ready[g]   = (r_level != LVL_W'(FIFO_DEPTH));
    assign w_nonempty[g] = (r_level != '0);
    assign w_push[g]     = ch_valid[g] && ch_ready[g] && !flush;
    assign w_pop[g]      = w_load && (w_gnt == CH_W'(g));
    assign w_ch_head[g]  = r_mem[r_rptr];
    assign ch_level[g*LVL_W +: LVL_W] = r_level;

    // Storage is not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
      if (w_push[g]) begin
        r_mem[r_wptr] <= w_wdata;
      end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push[g]) begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
        if (w_pop[g]) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        r_level <= r_level + LVL_W'(w_push[g]) - LVL_W'(w_pop[g]);
      end
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((32'(r_last) + 32'(k)) % NUM_CH);
      if (!w_any && w_nonempty[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_head = w_ch_head[w_gnt];

  // Output register and arbitration history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ch    <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_loadable) begin
      if (w_any) begin
        {r_op, r_a, r_b} <= w_head;
        r_ch    <= w_gnt;
        r_last  <= w_gnt;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Completed handshakes; a handshake in a flush cycle is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_count <= '0;
    end else if (!flush && r_valid && alu_ready) begin
      r_issue_count <= r_issue_count + 16'd1;
    end
  end

  assign alu_valid   = r_valid;
  assign alu_op      = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_ch      = r_ch;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_in_rr_issuer.sv
`timescale 1ns/1ps
// Self-checking bench for alu_in_rr_issuer: directed steps with a
// scoreboard queue of expected issued words checked at each handshake.
module tb_alu_in_rr_issuer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [11:0] ch_op;
  logic [31:0] ch_a;
  logic [31:0] ch_b;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_ch;
  logic [11:0] ch_level;
  logic [15:0] issue_count;

  logic [2:0]  tb_op [4];
  logic [7:0]  tb_a  [4];
  logic [7:0]  tb_b  [4];

  assign ch_op = {tb_op[3], tb_op[2], tb_op[1], tb_op[0]};
  assign ch_a  = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
  assign ch_b  = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};

  alu_in_rr_issuer #(
    .NUM_CH(4), .DATA_WIDTH(8), .OP_WIDTH(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_op(ch_op), .ch_a(ch_a), .ch_b(ch_b),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ch(alu_ch),
    .ch_level(ch_level), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] c, input logic [2:0] op,
                              input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.ch = c; e.op = op; e.a = a; e.b = b;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input logic [1:0] c, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b);
    ch_valid[c] = 1'b1;
    tb_op[c] = op;
    tb_a[c]  = a;
    tb_b[c]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ch_valid = '0;
    flush = 1'b0;
    sb.delete();
    exp_cnt = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: sampled mid-cycle, handshake completes at next edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("issue_count", 32'(issue_count), 32'(exp_cnt));
      if (alu_valid && alu_ready && !flush) begin
        n_tests++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_issue: observed ch=%0d a=%0h expected=none", alu_ch, alu_a);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("issue_word", 32'({alu_ch, alu_op, alu_a, alu_b}), 32'(e));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    exp_t e;
    rst = 1'b0; flush = 1'b0; ch_valid = '0; alu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_op[i] = '0; tb_a[i] = '0; tb_b[i] = '0;
    end

    // Reset / idle
    sb.delete();
    exp_cnt = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(alu_valid), 32'(0));
    chk("rst_ready", 32'(ch_ready), 32'hf);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_valid", 32'(alu_valid), 32'(0));
    chk("idle_bus", 32'({alu_ch, alu_op, alu_a, alu_b}), 32'(0));
    chk("idle_level", 32'(ch_level), 32'(0));
    chk("idle_count", 32'(issue_count), 32'(0));
    chk("idle_ready", 32'(ch_ready), 32'hf);

    // Single channel latency
    alu_ready = 1'b1;
    drive_ch(2'd2, 3'd1, 8'h12, 8'h34);
    sb.push_back(mk(2'd2, 3'd1, 8'h12, 8'h34));
    tick();
    ch_valid = '0;
    chk("lat_not_yet", 32'(alu_valid), 32'(0));
    chk("lat_level", 32'(ch_level[8:6]), 32'(1));
    tick();
    chk("lat_valid", 32'(alu_valid), 32'(1));
    chk("lat_word", 32'({alu_ch, alu_op, alu_a, alu_b}), 32'({2'd2, 3'd1, 8'h12, 8'h34}));
    tick();
    chk("lat_count", 32'(issue_count), 32'(1));
    chk("lat_drained", 32'(alu_valid), 32'(0));

    // Round-robin fairness
    do_reset();
    alu_ready = 1'b0;
    for (int ei = 0; ei < 2; ei++) begin
      for (int c = 0; c < 4; c++) begin
        drive_ch(2'(c), 3'(c + ei), 8'(c * 16 + ei), ~8'(c * 16 + ei));
        sb.push_back(mk(2'(c), 3'(c + ei), 8'(c * 16 + ei), ~8'(c * 16 + ei)));
      end
      tick();
    end
    ch_valid = '0;
    tick();
    chk("rr_levels", 32'(ch_level), 32'h491);
    chk("rr_first", 32'({alu_valid, alu_ch}), 32'({1'b1, 2'd0}));
    alu_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_seq", 32'({alu_valid, alu_ch}), 32'({1'b1, 2'(k % 4)}));
      tick();
    end
    chk("rr_count", 32'(issue_count), 32'(8));
    chk("rr_drained", 32'(alu_valid), 32'(0));

    // Backpressure / full
    do_reset();
    alu_ready = 1'b0;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 20) begin
      drive_ch(2'd1, 3'(n), 8'(8'ha0 + 8'(n)), 8'(n * 3));
      if (ch_ready[1]) begin
        sb.push_back(mk(2'd1, 3'(n), 8'(8'ha0 + 8'(n)), 8'(n * 3)));
        n++;
      end
      guard++;
      tick();
    end
    chk("bp_pushes", 32'(n), 32'(5));
    drive_ch(2'd1, 3'd7, 8'hee, 8'hee);
    chk("bp_full_ready", 32'(ch_ready[1]), 32'(0));
    chk("bp_full_level", 32'(ch_level[5:3]), 32'(4));
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", 32'({alu_valid, alu_ch, alu_op, alu_a, alu_b}),
          32'({1'b1, 2'd1, 3'd0, 8'ha0, 8'h00}));
      tick();
    end
    chk("bp_level_kept", 32'(ch_level[5:3]), 32'(4));
    ch_valid = '0;
    alu_ready = 1'b1;
    tick();
    chk("bp_ready_back", 32'(ch_ready[1]), 32'(1));
    chk("bp_level_pop", 32'(ch_level[5:3]), 32'(3));
    repeat (4) tick();
    chk("bp_count", 32'(issue_count), 32'(5));
    chk("bp_drained", 32'(alu_valid), 32'(0));

    // Flush mid-stream
    do_reset();
    alu_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_ch(2'd0, 3'(k), 8'(8'h50 + 8'(k)), 8'(k));
      tick();
    end
    ch_valid = '0;
    chk("fl_pre_level", 32'(ch_level[2:0]), 32'(3));
    chk("fl_pre_valid", 32'(alu_valid), 32'(1));
    flush = 1'b1;
    alu_ready = 1'b1;
    drive_ch(2'd0, 3'd5, 8'h77, 8'h77);
    tick();
    flush = 1'b0;
    ch_valid = '0;
    sb.delete();
    chk("fl_valid", 32'(alu_valid), 32'(0));
    chk("fl_level", 32'(ch_level), 32'(0));
    chk("fl_count", 32'(issue_count), 32'(0));
    repeat (2) tick();
    chk("fl_push_dropped", 32'(alu_valid), 32'(0));
    // last grant (ch0) survives the flush, so ch1 wins the tie
    drive_ch(2'd0, 3'd2, 8'h60, 8'h61);
    drive_ch(2'd1, 3'd3, 8'h70, 8'h71);
    sb.push_back(mk(2'd1, 3'd3, 8'h70, 8'h71));
    sb.push_back(mk(2'd0, 3'd2, 8'h60, 8'h61));
    tick();
    ch_valid = '0;
    tick();
    chk("fl_rr_kept", 32'({alu_valid, alu_ch}), 32'({1'b1, 2'd1}));
    repeat (2) tick();
    chk("fl_post_count", 32'(issue_count), 32'(2));

    // Reset mid-transfer drops buffered and in-flight requests
    alu_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_ch(2'd2, 3'(k), 8'(k), 8'(k));
      tick();
    end
    ch_valid = '0;
    #2;
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0;
    #1;
    chk("arst_valid", 32'(alu_valid), 32'(0));
    chk("arst_level", 32'(ch_level), 32'(0));
    chk("arst_count", 32'(issue_count), 32'(0));
    tick();
    rst = 1'b1;
    tick();
    chk("arst_dropped", 32'(alu_valid), 32'(0));

    // Counter wrap: 65536 handshakes with continuous traffic on ch3
    alu_ready = 1'b1;
    n = 0;
    while (n < 65536) begin
      drive_ch(2'd3, 3'(n), 8'(n), 8'(n >> 8));
      if (ch_ready[3]) begin
        sb.push_back(mk(2'd3, 3'(n), 8'(n), 8'(n >> 8)));
        n++;
      end
      tick();
    end
    ch_valid = '0;
    guard = 0;
    while ((alu_valid || sb.size() != 0) && guard < 20) begin
      guard++;
      tick();
    end
    chk("wrap_drained", 32'(alu_valid), 32'(0));
    chk("wrap_sb_empty", 32'(sb.size()), 32'(0));
    chk("wrap_count", 32'(issue_count), 32'(0));
    drive_ch(2'd3, 3'd6, 8'hc3, 8'h3c);
    sb.push_back(mk(2'd3, 3'd6, 8'hc3, 8'h3c));
    tick();
    ch_valid = '0;
    repeat (2) tick();
    chk("wrap_after", 32'(issue_count), 32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
